// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready merge with round-robin arbitration into a
// registered single-entry output stage. Define RR_ARB_MUX_FIXED_PRIO_EN for lowest-index-wins priority.
module rr_arb_mux #(
  parameter  int DATA_W = 16,
  parameter  int N_IN   = 3,
  localparam int SEL_W  = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [N_IN-1:0]        in_valid,
  output logic [N_IN-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic [SEL_W-1:0]  ptr_s;
  logic              hi_vld_s;
  logic              lo_vld_s;
  logic [SEL_W-1:0]  hi_idx_s;
  logic [SEL_W-1:0]  lo_idx_s;
  logic              gnt_vld_s;
  logic [SEL_W-1:0]  gnt_idx_s;
  logic [DATA_W-1:0] gnt_data_s;
  logic              can_accept_s;
  logic              xfer_s;

  logic              out_valid_q;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;
  logic [SEL_W-1:0]  out_sel_q;
  logic [SEL_W-1:0]  out_sel_d;

  // Split the search at ptr: lowest valid index at/above ptr wins, else lowest below it.
  always_comb begin
    hi_vld_s = 1'b0;
    lo_vld_s = 1'b0;
    hi_idx_s = {SEL_W{1'b0}};
    lo_idx_s = {SEL_W{1'b0}};
    for (int i = N_IN - 1; i >= 0; i--) begin
      hi_idx_s = (in_valid[i] && (SEL_W'(i) >= ptr_s)) ? SEL_W'(i) : hi_idx_s;
      hi_vld_s = hi_vld_s | (in_valid[i] & (SEL_W'(i) >= ptr_s));
      lo_idx_s = (in_valid[i] && (SEL_W'(i) < ptr_s)) ? SEL_W'(i) : lo_idx_s;
      lo_vld_s = lo_vld_s | (in_valid[i] & (SEL_W'(i) < ptr_s));
    end
    gnt_vld_s = hi_vld_s | lo_vld_s;
    gnt_idx_s = hi_vld_s ? hi_idx_s : lo_idx_s;
  end

  assign can_accept_s = ~out_valid_q | out_ready;
  assign xfer_s       = gnt_vld_s & can_accept_s;

  // Winner data mux and one-hot ready back to the granted producer.
  always_comb begin
    gnt_data_s = {DATA_W{1'b0}};
    in_ready   = {N_IN{1'b0}};
    for (int i = 0; i < N_IN; i++) begin
      gnt_data_s  = (gnt_idx_s == SEL_W'(i)) ? in_data[i*DATA_W +: DATA_W] : gnt_data_s;
      in_ready[i] = xfer_s & (gnt_idx_s == SEL_W'(i));
    end
  end

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
  assign ptr_s = {SEL_W{1'b0}};
`else
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic [SEL_W-1:0] ptr_nxt_s;

  // Explicit wrap so non-power-of-two N_IN never reaches an out-of-range pointer.
  assign ptr_nxt_s = (gnt_idx_s == SEL_W'(N_IN - 1)) ? {SEL_W{1'b0}} : gnt_idx_s + SEL_W'(1);

  // Pointer advances past the winner only on a transfer.
  always_comb begin
    if (xfer_s) begin
      ptr_d = ptr_nxt_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr_q <= {SEL_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_s = ptr_q;
`endif

  // Output stage: refill on transfer, drain to empty when consumed with no refill, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data_s;
      out_sel_d   = gnt_idx_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_sel_q   <= {SEL_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel successor to the 3-input select mux.
- Selects among N_IN valid/ready input channels by round-robin arbitration, not by an external select.
- Registers the winner into a single-entry output stage.
- Used wherever several pipeline producers share one consumer, e.g. writeback or memory-request merge; 1-cycle latency, full throughput.

Parameters:
- DATA_W, 16, width of each data channel in bits.
- N_IN, 3, number of input channels, legal range 2..16.
- SEL_W, $clog2(N_IN), width of the granted-index output; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- arst_n  input  1  asynchronous active-low reset.
- in_data  input  N_IN*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  N_IN  per-channel valid.
- in_ready  output  N_IN  per-channel ready; combinational, one-hot or zero.
- out_data  output  DATA_W  registered winning data.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  output stage holds valid data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- One clock domain; arst_n is asynchronous and active-low and is the only reset.
- Reset values: out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0; in_ready=0 follows from reset state only if no in_valid is high.
- Output stage states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_accept = !out_valid | out_ready.
- Grant (combinational):
  - Search in_valid starting at index ptr, ascending, wrapping N_IN-1 -> 0.
  - First set bit is the grant g; if no bit is set, there is no grant.
- in_ready[g] = can_accept; all other in_ready bits = 0.
  - in_ready never depends on in_valid of the same channel except through the grant.
- Transfer on input i: in_valid[i] & in_ready[i] at a rising clk edge. On that edge:
  - out_data <= channel g data; out_sel <= g; out_valid <= 1.
  - ptr <= (g+1) mod N_IN, with an explicit wrap compare; N_IN need not be a power of two.
- FULL & out_ready & no grant: out_valid <= 0 (EMPTY); out_data and out_sel hold their last values.
- FULL & out_ready & grant: simultaneous drain and refill; out_valid stays 1 and new data loads. This gives back-to-back throughput of 1 word/cycle.
- FULL & !out_ready: out_data, out_sel and out_valid are held stable; all in_ready=0; ptr holds.
- EMPTY & no grant: nothing changes.
- Fairness: a continuously valid channel is granted within N_IN transfers.
- Reset mid-operation: held output word is discarded; out_valid=0 on the next sampled value; ptr=0.
- No combinational path from in_data to out_data.

Optional Feature:
- Macro: RR_ARB_MUX_FIXED_PRIO_EN.
- Defined:
  - Grant is fixed priority, lowest valid index wins.
  - ptr register is removed; search always starts at 0.
  - All other handshake and register behaviour is identical.
- Undefined (default): round-robin as above.

Test Plan:
- Reset and idle: assert arst_n=0 mid-clock with out_valid=1 -> out_valid, out_data and out_sel go to 0 immediately, before the next clk edge. Release with all in_valid=0 -> out_valid stays 0 and in_ready=0.
- Single channel: in_valid=3'b010, ch1 data=16'hBEEF, out_ready=1 -> in_ready=3'b010. Next cycle out_valid=1, out_data=16'hBEEF, out_sel=1, ptr=2.
- Round-robin: in_valid=3'b111 held, out_ready=1, ch data 16'h000A/16'h000B/16'h000C -> out_sel sequence 0,1,2,0,1,2 on consecutive cycles. out_valid stays high with no bubbles.
- Backpressure: out FULL with 16'h1234, out_ready=0 for 4 cycles with inputs valid -> out_data remains 16'h1234, in_ready=0 throughout. Raising out_ready -> the 16'h1234 word transfers, and the next grant loads on the same edge.
- Wrap with non-power-of-two N_IN=3: ptr=2, in_valid=3'b001 -> grant 0 and ptr becomes 1. With ptr=2 and in_valid=3'b101 -> grant 2 and ptr becomes 0, never 3.
- With RR_ARB_MUX_FIXED_PRIO_EN defined: in_valid=3'b110 held, out_ready=1 -> out_sel=1 every cycle and channel 2 is never granted.
